// File: rtl/sram_axi_pkg.sv
// Shared types for the SRAM AXI burst slave: arbitration codes, response codes, FSM states.
package sram_axi_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        WRONG = 2'd3
    } sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        WRESP = 2'd3
    } state_e;

endpackage

// File: rtl/sram_burst_addr_gen.sv
// Burst address/beat tracker: latched word address, beat counter and last-beat compare.
module sram_burst_addr_gen #(
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [SRAM_AW-1:0] load_addr,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               adv,
    output logic [SRAM_AW-1:0] addr,
    output logic [SRAM_AW-1:0] addr_inc,
    output logic               at_len,
    output logic               past
);

    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               past_q, past_d;

    assign addr     = addr_q;
    assign addr_inc = addr_q + SRAM_AW'(1);
    assign at_len   = (cnt_q == len_q);
    assign past     = past_q;

    // The counter saturates at LEN; past marks beats beyond the burst length.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        past_d = past_q;
        if (load) begin
            addr_d = load_addr;
            len_d  = load_len;
            cnt_d  = '0;
            past_d = 1'b0;
        end else if (adv) begin
            addr_d = addr_inc;
            if (at_len) past_d = 1'b1;
            else        cnt_d  = cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            past_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            past_q <= past_d;
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// AXI4 INCR burst slave driving a single-port SRAM macro; one transaction at a time,
// gated by the upstream read/write arbitration code.
module sram_burst_ctrl
    import sram_axi_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [1:0]          sel,
    input  logic [ID_W-1:0]     ARID,
    input  logic [31:0]         ARADDR,
    input  logic [LEN_W-1:0]    ARLEN,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    input  logic [ID_W-1:0]     AWID,
    input  logic [31:0]         AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic                sram_ceb,
    output logic                sram_web,
    output logic [DATA_W-1:0]   sram_bweb,
    output logic [SRAM_AW-1:0]  sram_a,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              err_q, err_d;

    logic               ag_load, ag_adv, ag_at_len, ag_past;
    logic [SRAM_AW-1:0] ag_load_addr, ag_addr, ag_addr_inc;
    logic [LEN_W-1:0]   ag_load_len;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ARADDR[31:SRAM_AW+2], ARADDR[1:0],
                                AWADDR[31:SRAM_AW+2], AWADDR[1:0]};

    sram_burst_addr_gen #(.LEN_W(LEN_W), .SRAM_AW(SRAM_AW)) u_addr_gen (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .load      (ag_load),
        .load_addr (ag_load_addr),
        .load_len  (ag_load_len),
        .adv       (ag_adv),
        .addr      (ag_addr),
        .addr_inc  (ag_addr_inc),
        .at_len    (ag_at_len),
        .past      (ag_past)
    );

    assign RVALID = (state_q == RD);
    assign RLAST  = RVALID && ag_at_len;
    assign RDATA  = sram_do;
    assign RRESP  = RESP_OKAY;
    assign RID    = id_q;
    assign BID    = id_q;
    assign BRESP  = bresp_q;
    assign BVALID = (state_q == WRESP);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        bresp_d      = bresp_q;
        err_d        = err_q;
        ag_load      = 1'b0;
        ag_load_addr = '0;
        ag_load_len  = '0;
        ag_adv       = 1'b0;
        ARREADY      = 1'b0;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        sram_ceb     = 1'b1;
        sram_web     = 1'b1;
        sram_bweb    = '1;
        sram_a       = ag_addr;
        sram_di      = '0;
        unique case (state_q)
            IDLE: begin
                ARREADY = (sel == READ);
                AWREADY = (sel == WRITE);
                if (ARREADY && ARVALID) begin
                    id_d         = ARID;
                    ag_load      = 1'b1;
                    ag_load_addr = ARADDR[SRAM_AW+1:2];
                    ag_load_len  = ARLEN;
                    // First word is fetched now so RDATA is ready one cycle later.
                    sram_ceb     = 1'b0;
                    sram_a       = ARADDR[SRAM_AW+1:2];
                    state_d      = RD;
                end else if (AWREADY && AWVALID) begin
                    id_d         = AWID;
                    ag_load      = 1'b1;
                    ag_load_addr = AWADDR[SRAM_AW+1:2];
                    ag_load_len  = AWLEN;
                    state_d      = WR;
                end
            end
            RD: begin
                // Re-reading the current word on a stall keeps RDATA stable.
                sram_ceb = 1'b0;
                if (RREADY) begin
                    ag_adv = 1'b1;
                    sram_a = ag_addr_inc;
                    if (ag_at_len) state_d = IDLE;
                end
            end
            WR: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    if (!ag_past) begin
                        ag_adv   = 1'b1;
                        sram_ceb = 1'b0;
                        sram_web = 1'b0;
                        sram_di  = WDATA;
                        for (int k = 0; k < DATA_W/8; k++)
                            sram_bweb[8*k +: 8] = {8{~WSTRB[k]}};
                    end
                    if (WLAST) begin
                        bresp_d = (err_q || ag_past || !ag_at_len) ? RESP_SLVERR : RESP_OKAY;
                        state_d = WRESP;
                    end else if (ag_at_len && !ag_past) begin
                        err_d = 1'b1;
                    end
                end
            end
            WRESP: begin
                if (BREADY) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            bresp_q <= RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            bresp_q <= bresp_d;
            err_q   <= err_d;
        end
    end

endmodule
